// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter:
// ALU control codes, FSM state encoding, default width.
package alu_arbiter_pkg;

  localparam int DATA_W_DEFAULT = 32;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CAPT,
    ST_RESP
  } state_t;

  function automatic logic is_supported(input logic [3:0] c);
    case (c)
      CTRL_AND, CTRL_OR, CTRL_ADD,
      CTRL_SUB, CTRL_SLT, CTRL_NOR: is_supported = 1'b1;
      default:                      is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between requesters and the arbiter.
// master: requesters + response consumer; slave: the arbiter.
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_src1;
  logic [2*DATA_W-1:0] req_src2;
  logic [7:0]          req_ctrl;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [DATA_W-1:0]   rsp_result;
  logic                rsp_zero;
  logic                rsp_cout;
  logic                rsp_overflow;
  logic                rsp_err;

  modport master (
    output req_valid, req_src1, req_src2,
    output req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_result, rsp_zero, rsp_cout,
    input  rsp_overflow, rsp_err
  );

  modport slave (
    input  req_valid, req_src1, req_src2,
    input  req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_id,
    output rsp_result, rsp_zero, rsp_cout,
    output rsp_overflow, rsp_err
  );
endinterface

// File: rtl/alu_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick.
// Ports: valid[1:0], ptr (favoured requester), grant[1:0] one-hot/zero.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);
  import alu_arbiter_pkg::*;

  // A requester wins if favoured or if the other one is idle.
  assign grant[0] = valid[0] & (~ptr | ~valid[1]);
  assign grant[1] = valid[1] & ( ptr | ~valid[0]);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters, round-robin.
// Ports: clk, rst_n, bus (slave), alu_src1/2/ctrl out, alu_* flags in.
import alu_arbiter_pkg::*;

module alu_arbiter #(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_cout,
  input  logic              alu_overflow
);

  state_t            state;
  logic              ptr;
  logic [1:0]        grant;
  logic [1:0]        hs;
  logic              sel;
  logic [3:0]        sel_ctrl;
  logic [DATA_W-1:0] sel_src1;
  logic [DATA_W-1:0] sel_src2;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_cout;
  logic              rsp_overflow;
  logic              rsp_err;

  rr_pick2 u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Ready held low while reset is asserted.
  assign bus.req_ready =
    (state == ST_IDLE && rst_n) ? grant : 2'b00;

  assign hs  = bus.req_valid & bus.req_ready;
  assign sel = hs[1];

  assign sel_ctrl = sel ? bus.req_ctrl[7:4]
                        : bus.req_ctrl[3:0];
  assign sel_src1 = sel ? bus.req_src1[2*DATA_W-1:DATA_W]
                        : bus.req_src1[DATA_W-1:0];
  assign sel_src2 = sel ? bus.req_src2[2*DATA_W-1:DATA_W]
                        : bus.req_src2[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= 1'b0;
      alu_src1     <= '0;
      alu_src2     <= '0;
      alu_ctrl     <= 4'b0000;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|hs) begin
            rsp_id <= sel;
            if (is_supported(sel_ctrl)) begin
              alu_src1 <= sel_src1;
              alu_src2 <= sel_src2;
              alu_ctrl <= sel_ctrl;
              state    <= ST_DRIVE;
            end else begin
              // Unsupported code: answer directly,
              // ALU operands left untouched.
              rsp_result   <= '0;
              rsp_zero     <= 1'b1;
              rsp_cout     <= 1'b0;
              rsp_overflow <= 1'b0;
              rsp_err      <= 1'b1;
              rsp_valid    <= 1'b1;
              state        <= ST_RESP;
            end
          end
        end
        ST_DRIVE: state <= ST_CAPT;
        ST_CAPT: begin
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_cout     <= alu_cout;
          rsp_overflow <= alu_overflow;
          rsp_err      <= 1'b0;
          rsp_valid    <= 1'b1;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= ~rsp_id;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_id       = rsp_id;
  assign bus.rsp_result   = rsp_result;
  assign bus.rsp_zero     = rsp_zero;
  assign bus.rsp_cout     = rsp_cout;
  assign bus.rsp_overflow = rsp_overflow;
  assign bus.rsp_err      = rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: registered ALU model, directed + random ops.
// Checks grant order, latency, response fields, hold and reset.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, alu_cout, alu_overflow;

  int total = 0;
  int bad   = 0;

  alu_arbiter_if #(.DATA_W(32)) bus ();

  alu_arbiter #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // {overflow, cout, zero, result}
  function automatic logic [34:0] alu_f(input logic [3:0] c,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        co, ov;
    co = 0; ov = 0; r = 0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0110, 4'b0111: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
        if (c == 4'b0111)
          r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      end
      default: r = 0;
    endcase
    return {ov, co, (r == 0), r};
  endfunction

  function automatic bit sup(input logic [3:0] c);
    return c == 4'h0 || c == 4'h1 || c == 4'h2 ||
           c == 4'h6 || c == 4'h7 || c == 4'hC;
  endfunction

  // External ALU: captures operands on the clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result <= 0; alu_zero <= 0;
      alu_cout <= 0; alu_overflow <= 0;
    end else begin
      {alu_overflow, alu_cout, alu_zero, alu_result}
        <= alu_f(alu_ctrl, alu_src1, alu_src2);
    end
  end

  int          prio;
  logic [3:0]  last_ctrl;
  logic [3:0]  p_ctrl[2];
  logic [31:0] p_a[2], p_b[2];
  logic [31:0] got_res;
  logic        got_z, got_v, got_e;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic present(input int i, input logic [3:0] c,
                         input logic [31:0] a,
                         input logic [31:0] b);
    p_ctrl[i] = c; p_a[i] = a; p_b[i] = b;
    bus.req_ctrl[i*4 +: 4]  = c;
    bus.req_src1[i*32 +: 32] = a;
    bus.req_src2[i*32 +: 32] = b;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic serve(input int hold);
    int          w, lat, n;
    logic [1:0]  vm;
    logic [34:0] e;
    bit          ok;
    #1;
    vm = bus.req_valid;
    w  = (vm == 2'b11) ? prio : (vm[1] ? 1 : 0);
    n  = 0;
    while (bus.req_ready == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    chk("grant_wait", (n < 20) ? 1 : 0, 1);
    chk("grant", bus.req_ready, 2'b01 << w);
    ok  = sup(p_ctrl[w]);
    lat = ok ? 3 : 1;
    e   = ok ? alu_f(p_ctrl[w], p_a[w], p_b[w])
             : {1'b0, 1'b0, 1'b1, 32'h0};
    tick();
    bus.req_valid[w] = 1'b0;
    for (int k = 1; k < lat; k++) begin
      chk("early_valid", bus.rsp_valid, 0);
      chk("busy_ready", bus.req_ready, 0);
      tick();
    end
    if (ok) last_ctrl = p_ctrl[w];
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_id", bus.rsp_id, w);
    chk("rsp_result", bus.rsp_result, e[31:0]);
    chk("rsp_flags", {bus.rsp_overflow, bus.rsp_cout,
                      bus.rsp_zero}, e[34:32]);
    chk("rsp_err", bus.rsp_err, !ok);
    chk("alu_ctrl", alu_ctrl, last_ctrl);
    got_res = bus.rsp_result; got_z = bus.rsp_zero;
    got_v = bus.rsp_overflow; got_e = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_result", bus.rsp_result, e[31:0]);
      chk("hold_flags", {bus.rsp_overflow, bus.rsp_cout,
                         bus.rsp_zero}, e[34:32]);
      chk("hold_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    chk("take_ready", bus.req_ready, 0);
    tick();
    bus.rsp_ready = 1'b0;
    chk("after_valid", bus.rsp_valid, 0);
    chk("after_result", bus.rsp_result, e[31:0]);
    prio = 1 - w;
  endtask

  initial begin
    logic [3:0] codes [6];
    int         m;
    codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
    rst_n = 0;
    bus.req_valid = 2'b11;
    bus.req_src1 = '0; bus.req_src2 = '0;
    bus.req_ctrl = '0; bus.rsp_ready = 0;
    prio = 0; last_ctrl = 0;
    tick(); tick();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_fields", {bus.rsp_id, bus.rsp_err, bus.rsp_zero,
                       bus.rsp_cout, bus.rsp_overflow}, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_alu", {alu_src1, alu_src2, alu_ctrl}, 0);
    bus.req_valid = 2'b00;
    rst_n = 1;
    tick();

    // Both requesters SUB 3-3: 0 first, then 1.
    present(0, CTRL_SUB, 3, 3);
    present(1, CTRL_SUB, 3, 3);
    serve(0);
    chk("sub0_res", {got_res, got_z}, {32'h0, 1'b1});
    serve(0);
    chk("sub1_res", {got_res, got_z}, {32'h0, 1'b1});

    present(0, CTRL_ADD, 5, 7);
    serve(0);
    chk("add_res", {got_res, got_z, got_e}, {32'd12, 2'b00});

    present(1, 4'hF, 32'h1234, 32'h5678);
    serve(0);
    chk("bad_code", {got_res, got_e}, {32'h0, 1'b1});

    present(0, CTRL_ADD, 32'h7FFFFFFF, 32'h1);
    serve(5);
    chk("ovf_res", {got_res, got_v}, {32'h80000000, 1'b1});

    present(1, CTRL_SLT, 32'hFFFFFFFF, 32'h1);
    serve(0);
    chk("slt_res", got_res, 32'h1);
    present(0, CTRL_NOR, 32'h0, 32'h0);
    serve(0);
    chk("nor_res", got_res, 32'hFFFFFFFF);

    // Reset pulse while the operation sits in CAPT.
    present(0, CTRL_ADD, 1, 2);
    #1;
    chk("mid_grant", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    tick();
    rst_n = 0;
    #1;
    chk("mid_valid", bus.rsp_valid, 0);
    chk("mid_ready", bus.req_ready, 0);
    chk("mid_fields", {bus.rsp_id, bus.rsp_err, bus.rsp_zero,
                       bus.rsp_cout, bus.rsp_overflow}, 0);
    chk("mid_result", bus.rsp_result, 0);
    chk("mid_alu", {alu_src1, alu_src2, alu_ctrl}, 0);
    tick();
    rst_n = 1;
    prio = 0; last_ctrl = 0;
    tick(); tick();
    chk("mid_norsp", bus.rsp_valid, 0);
    present(1, CTRL_OR, 32'hF0, 32'h0F);
    present(0, CTRL_AND, 32'hFF, 32'h3C);
    serve(1);
    serve(0);

    for (int it = 0; it < 30; it++) begin
      m = $urandom_range(1, 3);
      for (int i = 0; i < 2; i++) begin
        if (m[i]) begin
          logic [3:0] c;
          c = ($urandom_range(0, 4) == 0)
                ? 4'($urandom) : codes[$urandom_range(0, 5)];
          present(i, c, $urandom, $urandom);
        end
      end
      serve($urandom_range(0, 2));
      if (bus.req_valid != 2'b00) serve($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
